// File: rtl/nebula_fifo_arbiter_if.sv
// Requester-side and FIFO-write-side signal bundle for nebula_fifo_arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface nebula_fifo_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_full;
    logic                          fifo_almost_full;

    modport master (
        output req_valid, req_data, req_last, fifo_full, fifo_almost_full,
        input  req_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full, fifo_almost_full,
        output req_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/nebula_fifo_arbiter.sv
// Packet-level round-robin arbiter sharing one nebula_fifo write port among NUM_REQ requesters.
// Optional macro NEBULA_ARB_AF_THROTTLE_EN: hold off new grants while fifo_almost_full is high.
module nebula_fifo_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int GID_W      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    nebula_fifo_arbiter_if.slave bus,
    output logic [GID_W-1:0]     grant_id,
    output logic                 busy
);
    typedef enum logic {IDLE, BURST} state_e;

    state_e           state_q;
    logic [GID_W-1:0] prio_ptr_q;
    logic [GID_W-1:0] grant_q;
    logic             busy_q;

    logic             pick_found;
    logic [GID_W-1:0] pick_idx;
    logic [GID_W:0]   cand;
    logic             arb_en;
    logic             gnt_valid;
    logic             gnt_last;
    logic             xfer;

    // Rotating first-set scan starting at prio_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, prio_ptr_q} + (GID_W+1)'(k);
            if (cand >= (GID_W+1)'(NUM_REQ)) begin
                cand = cand - (GID_W+1)'(NUM_REQ);
            end
            if (!pick_found && bus.req_valid[cand[GID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[GID_W-1:0];
            end
        end
    end

`ifdef NEBULA_ARB_AF_THROTTLE_EN
    assign arb_en = !bus.fifo_almost_full;
`else
    logic unused_af;
    assign arb_en    = 1'b1;
    assign unused_af = bus.fifo_almost_full;
`endif

    assign gnt_valid = bus.req_valid[grant_q];
    assign gnt_last  = bus.req_last[grant_q];

    // Reset gates the write strobe in the same cycle so an abandoned packet leaks nothing.
    assign xfer = !rst && (state_q == BURST) && gnt_valid && !bus.fifo_full;

    always_comb begin
        bus.req_ready = '0;
        if (!rst && (state_q == BURST) && !bus.fifo_full) begin
            bus.req_ready[grant_q] = 1'b1;
        end
    end

    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_wr_data = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_ptr_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found && arb_en) begin
                        grant_q <= pick_idx;
                        state_q <= BURST;
                        busy_q  <= 1'b1;
                    end
                end
                BURST: begin
                    if (xfer && gnt_last) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        prio_ptr_q <= (grant_q == GID_W'(NUM_REQ-1)) ? '0 : grant_q + GID_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
endmodule
